reg_bus_arbiter: RTL and testbench
==================================

# reg_bus_arbiter

Shares the 7-bit-address / 32-bit-data control register bus between two masters: the in-band command reader (port 0) and a second control master (port 1, e.g. the serial/host register path). Each port gets a one-deep request slot. A round-robin scheduler issues one write or read at a time to the register file and returns read data to the requesting port only. Sits between the masters' `reg_io_enable`/`reg_addr`/`reg_data_in` outputs and the register file, on the `txclk` domain.

## Interface
Parameters:
- `READ_LATENCY`, 1: clocks from the cycle `reg_re` is high to the cycle `reg_rdata` is valid; legal range 1..7.

Ports:
- `txclk`  in  1  sole clock, all logic on rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `m0_en`, `m1_en`  in  2 each  request code: 2'd2 write, 2'd3 read, 2'd0/2'd1 no request.
- `m0_addr`, `m1_addr`  in  7 each  register address.
- `m0_wdata`, `m1_wdata`  in  32 each  write data.
- `m0_busy`, `m1_busy`  out  1 each  port slot occupied.
- `m0_rdata`, `m1_rdata`  out  32 each  read reply data.
- `m0_rvalid`, `m1_rvalid`  out  1 each  one-cycle reply strobe.
- `reg_addr`  out  7  register file address.
- `reg_wdata`  out  32  register file write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  32  register file read data.
- `clr_overrun`  in  1  clears `overrun`.
- `overrun`  out  2  sticky per-port dropped-request flags.
- `debug`  out  4  {state[1:0], grant, |busy}.

## Operation
- Request detection, per port: a request is a cycle where `en[1]==1` and `en` differs from its value in the previous cycle. A level held at 2'd2 or 2'd3 counts once. A change 2'd2→2'd3 counts as a new request.
- Capture: if the slot is empty, the slot latches {rd = en[0], addr, wdata} and `busy` goes high. If the slot is full, the request is dropped and `overrun[port]` is set.
- FSM states:
  - IDLE: if any slot is full, select a port. If only one slot is full, select it. If both are full, select the port ≠ `last_grant`. Drive `reg_addr`/`reg_wdata` from the selected slot.
    - Write: pulse `reg_we`, clear the slot, set `last_grant`, stay in IDLE.
    - Read: pulse `reg_re`, go to READ_WAIT.
  - READ_WAIT: counter runs from `READ_LATENCY`. When it expires, capture `reg_rdata` and go to RESPOND.
  - RESPOND: drive the captured data on the owner's `mX_rdata` and pulse `mX_rvalid` for one cycle. Clear the owner's slot, set `last_grant`, return to IDLE.
- The non-owner's `rdata` holds its last value; its `rvalid` stays 0.
- `reg_we` and `reg_re` are never high in the same cycle. Only one transaction is outstanding at a time.
- Same-cycle events:
  - Capture on one port while the other is being served: both happen.
  - A slot is cleared on the same edge a new request arrives on that port: the request is dropped with overrun, because slot-full is sampled before the edge.
  - `clr_overrun` and a new drop in the same cycle: the flag ends set (set wins).
- Reset (`reset_n==0` at an edge): all slots are emptied and pending transactions are discarded without reply. The previous-`en` registers are loaded with 0. State is IDLE. `last_grant=1`, so port 0 wins first.

## Timing
- Reset values: `busy`=0, `rvalid`=0, `rdata`=0, `reg_we`=0, `reg_re`=0, `reg_addr`=0, `reg_wdata`=0, `overrun`=0, `debug`=0.
- Let E0 be the edge that samples a request into an empty slot and the FSM is in IDLE.
- Write timing:
  - `busy` is high after E0.
  - `reg_we` is high for the cycle after E1 (= E0+1).
  - `busy` is low after E1.
- Read timing:
  - `reg_re` is high for cycle C, after E1.
  - `reg_rdata` is sampled at the end of cycle C+`READ_LATENCY`.
  - `rvalid` is high in the following cycle, with `busy` low from the next edge.
  - Total request-to-`rvalid` = `READ_LATENCY`+2 clocks.
- Back-to-back writes from both ports: one `reg_we` per clock, alternating ports.

## Configuration
- `REG_ARB_FIXED_PRIORITY_EN`: when defined, port 0 always wins when both slots are full and `last_grant` is ignored. Port 1 may starve under continuous port-0 traffic.
- When undefined: round-robin as above.

## Test plan
- Port 0 holds `en`=2'd2 for 3 cycles, addr 7'h05, data 32'hDEADBEEF → exactly one `reg_we` with addr 05/DEADBEEF; `overrun`=0.
- `READ_LATENCY`=3, port 1 reads addr 7'h10, `reg_rdata`=32'h12345678 valid on the correct cycle → `m1_rvalid` 5 clocks after request with 32'h12345678; `m0_rvalid` stays 0.
- Both ports write in the same cycle after reset → port 0 `reg_we` first, port 1 next clock. Repeat → port 1 first (round robin); port 0 first again if `REG_ARB_FIXED_PRIORITY_EN` is defined.
- Port 0 read pending, second port 0 request 1 cycle later → second request dropped, `overrun`=2'b01; `clr_overrun` pulse → 2'b00.
- `reset_n` low during READ_WAIT → no `rvalid`, `busy`=0, all outputs at reset values; next request is served normally.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-master register bus arbiter with one-deep slots; REG_ARB_FIXED_PRIORITY_EN selects fixed port-0 priority
module reg_bus_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        txclk,
  input  logic        reset_n,
  input  logic [1:0]  m0_en,
  input  logic [1:0]  m1_en,
  input  logic [6:0]  m0_addr,
  input  logic [6:0]  m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_busy,
  output logic        m1_busy,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [6:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [31:0] reg_rdata,
  input  logic        clr_overrun,
  output logic [1:0]  overrun,
  output logic [3:0]  debug
);
  localparam logic [1:0] IDLE = 2'd0, READ_WAIT = 2'd1, RESPOND = 2'd2;
  logic [1:0]  state, prev0, prev1, busy, req, clr, slot_rd;
  logic        last_grant, owner, sel, issue;
  logic [2:0]  cnt;
  logic [6:0]  slot_addr [2];
  logic [31:0] slot_wdata [2];
  logic [6:0]  in_addr [2];
  logic [31:0] in_wdata [2];
  logic [1:0]  in_rd;
  assign in_addr[0] = m0_addr;
  assign in_addr[1] = m1_addr;
  assign in_wdata[0] = m0_wdata;
  assign in_wdata[1] = m1_wdata;
  assign in_rd = {m1_en[0], m0_en[0]};
  // a request is a new code with bit 1 set; a held level counts once
  assign req = {m1_en[1] && (m1_en != prev1), m0_en[1] && (m0_en != prev0)};
`ifdef REG_ARB_FIXED_PRIORITY_EN
  assign sel = ~busy[0];
`else
  assign sel = &busy ? ~last_grant : busy[1];
`endif
  assign issue = (state == IDLE) && |busy;
  assign clr[0] = (issue && !sel && !slot_rd[0]) || (state == RESPOND && !owner);
  assign clr[1] = (issue && sel && !slot_rd[1]) || (state == RESPOND && owner);
  assign {m1_busy, m0_busy} = busy;
  assign debug = {state, owner, |busy};
  // previous-en history for edge-style request detection
  always_ff @(posedge txclk) begin
    prev0 <= reset_n ? m0_en : 2'd0;
    prev1 <= reset_n ? m1_en : 2'd0;
  end
  // request slots; fullness is sampled before the edge so a clear and a new request collide as a drop
  always_ff @(posedge txclk) begin
    if (!reset_n) begin
      busy <= '0;
      slot_rd <= '0;
      overrun <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_addr[i] <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      overrun <= (clr_overrun ? 2'b00 : overrun) | (req & busy);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && !busy[i]) begin
          busy[i] <= 1'b1;
          slot_rd[i] <= in_rd[i];
          slot_addr[i] <= in_addr[i];
          slot_wdata[i] <= in_wdata[i];
        end else if (clr[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end
  // scheduler: issue one transaction at a time and route read replies to the owner
  always_ff @(posedge txclk) begin
    if (!reset_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      cnt <= '0;
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      reg_addr <= '0;
      reg_wdata <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: if (issue) begin
          reg_addr <= slot_addr[sel];
          reg_wdata <= slot_wdata[sel];
          owner <= sel;
          if (slot_rd[sel]) begin
            reg_re <= 1'b1;
            cnt <= 3'(READ_LATENCY);
            state <= READ_WAIT;
          end else begin
            reg_we <= 1'b1;
            last_grant <= sel;
          end
        end
        READ_WAIT: if (cnt == 3'd0) begin
          if (owner) begin
            m1_rdata <= reg_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata <= reg_rdata;
            m0_rvalid <= 1'b1;
          end
          state <= RESPOND;
        end else begin
          cnt <= cnt - 3'd1;
        end
        RESPOND: begin
          last_grant <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed checks of reg_bus_arbiter with READ_LATENCY=3 and a latency-accurate register file model
module tb_reg_bus_arbiter;
  logic        txclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m0_en = 2'd0, m1_en = 2'd0;
  logic [6:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_busy, m1_busy, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata, rd_val = '0;
  logic        reg_we, reg_re;
  logic        clr_overrun = 1'b0;
  logic [1:0]  overrun;
  logic [3:0]  debug;
  logic [2:0]  re_pipe = '0;
  int checks = 0, failures = 0, we_cnt = 0, both_cnt = 0;
  int lat, nv0, nv1, w0;
  reg_bus_arbiter #(.READ_LATENCY(3)) dut (
    .txclk(txclk), .reset_n(reset_n),
    .m0_en(m0_en), .m1_en(m1_en), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_busy(m0_busy), .m1_busy(m1_busy),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .clr_overrun(clr_overrun), .overrun(overrun), .debug(debug)
  );
  always #5 txclk = ~txclk;
  // register file model: data valid only in the cycle READ_LATENCY after reg_re
  always @(posedge txclk) begin
    re_pipe <= {re_pipe[1:0], reg_re};
    if (reg_we) we_cnt++;
    if (reg_we && reg_re) both_cnt++;
  end
  assign reg_rdata = re_pipe[2] ? rd_val : 32'hBAD0BAD0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge txclk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask
  initial begin
    tick();
    tick();
    check("rst_busy", {30'd0, m1_busy, m0_busy}, 0);
    check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    check("rst_we_re", {30'd0, reg_we, reg_re}, 0);
    check("rst_addr", {25'd0, reg_addr}, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_ovr_dbg", {26'd0, overrun, debug}, 0);
    reset_n = 1'b1;
    // held write level counts once
    w0 = we_cnt;
    m0_en = 2'd2; m0_addr = 7'h05; m0_wdata = 32'hDEADBEEF;
    tick();
    check("wr_busy_e0", {31'd0, m0_busy}, 1);
    check("wr_we_e0", {31'd0, reg_we}, 0);
    tick();
    check("wr_we_e1", {31'd0, reg_we}, 1);
    check("wr_addr", {25'd0, reg_addr}, 32'h05);
    check("wr_data", reg_wdata, 32'hDEADBEEF);
    check("wr_busy_e1", {31'd0, m0_busy}, 0);
    tick();
    m0_en = 2'd0;
    tick();
    tick();
    check("wr_once", we_cnt - w0, 1);
    check("wr_ovr", {30'd0, overrun}, 0);
    // port 1 read, latency 3
    m1_en = 2'd3; m1_addr = 7'h10; rd_val = 32'h12345678;
    tick();
    check("rd_busy", {31'd0, m1_busy}, 1);
    m1_en = 2'd0;
    lat = -1; nv0 = 0; nv1 = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) check("rd_re", {24'd0, reg_re, reg_addr}, {24'd0, 1'b1, 7'h10});
      if (m1_rvalid) begin
        nv1++;
        if (lat < 0) lat = k;
      end
      if (m0_rvalid) nv0++;
      if (k == 5) check("rd_data", m1_rdata, 32'h12345678);
      if (k == 5) check("rd_busy_resp", {31'd0, m1_busy}, 1);
      if (k == 6) check("rd_busy_done", {31'd0, m1_busy}, 0);
    end
    check("rd_latency", lat, 5);
    check("rd_pulse", nv1, 1);
    check("rd_m0_quiet", nv0, 0);
    check("rd_m0_rdata", m0_rdata, 0);
    // simultaneous writes: port 0 first after reset
    do_reset();
    m0_en = 2'd2; m0_addr = 7'h01; m0_wdata = 32'h111;
    m1_en = 2'd2; m1_addr = 7'h02; m1_wdata = 32'h222;
    tick();
    check("rr_both_busy", {30'd0, m1_busy, m0_busy}, 3);
    m0_en = 2'd0; m1_en = 2'd0;
    tick();
    check("rr1_first", {24'd0, reg_we, reg_addr}, {24'd0, 1'b1, 7'h01});
    check("rr1_dbg_a", {28'd0, debug}, 4'b0001);
    tick();
    check("rr1_second", {24'd0, reg_we, reg_addr}, {24'd0, 1'b1, 7'h02});
    check("rr1_dbg_b", {28'd0, debug}, 4'b0010);
    // port 0 alone, then both: round robin favours port 1
    m0_en = 2'd2; m0_addr = 7'h03;
    tick();
    m0_en = 2'd0;
    tick();
    check("rr_solo", {24'd0, reg_we, reg_addr}, {24'd0, 1'b1, 7'h03});
    m0_en = 2'd2; m0_addr = 7'h04;
    m1_en = 2'd2; m1_addr = 7'h05;
    tick();
    m0_en = 2'd0; m1_en = 2'd0;
    tick();
`ifdef REG_ARB_FIXED_PRIORITY_EN
    check("rr2_first", {24'd0, reg_we, reg_addr}, {24'd0, 1'b1, 7'h04});
    tick();
    check("rr2_second", {24'd0, reg_we, reg_addr}, {24'd0, 1'b1, 7'h05});
`else
    check("rr2_first", {24'd0, reg_we, reg_addr}, {24'd0, 1'b1, 7'h05});
    tick();
    check("rr2_second", {24'd0, reg_we, reg_addr}, {24'd0, 1'b1, 7'h04});
`endif
    // second request while port 0 read pending is dropped
    tick();
    w0 = we_cnt;
    rd_val = 32'hCAFEF00D;
    m0_en = 2'd3; m0_addr = 7'h07;
    tick();
    m0_en = 2'd2;
    tick();
    check("ovr_set", {30'd0, overrun}, 2'b01);
    m0_en = 2'd0;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_clr", {30'd0, overrun}, 0);
    nv0 = 0;
    for (int k = 0; k < 12 && nv0 == 0; k++) begin
      tick();
      if (m0_rvalid) nv0 = 1;
    end
    check("ovr_reply", nv0, 1);
    check("ovr_rdata", m0_rdata, 32'hCAFEF00D);
    tick();
    tick();
    check("ovr_no_write", we_cnt - w0, 0);
    // reset during READ_WAIT discards the read
    m1_en = 2'd3; m1_addr = 7'h20; rd_val = 32'h55AA55AA;
    tick();
    m1_en = 2'd0;
    tick();
    tick();
    check("rw_dbg", {28'd0, debug}, 4'b0111);
    do_reset();
    check("rw_busy", {30'd0, m1_busy, m0_busy}, 0);
    check("rw_outs", {23'd0, reg_we, reg_re, reg_addr}, 0);
    check("rw_rdata", m0_rdata | m1_rdata | reg_wdata, 0);
    check("rw_ovr_dbg", {26'd0, overrun, debug}, 0);
    nv1 = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (m1_rvalid || m0_rvalid) nv1++;
    end
    check("rw_no_reply", nv1, 0);
    m1_en = 2'd3; m1_addr = 7'h11; rd_val = 32'h0BADCAFE;
    tick();
    m1_en = 2'd0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (m1_rvalid && lat < 0) lat = k;
    end
    check("rw_next_lat", lat, 5);
    check("rw_next_data", m1_rdata, 32'h0BADCAFE);
    check("we_re_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
